// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types and constants for the general register file writeback arbiter.
// Holds the write-port record (pc / a3 / wd) carried through the MDU result FIFO
// and the output registers, plus the register-address width and the $0 address.
package grf_wb_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam logic [RegAddrW-1:0] ZeroReg = '0;

  typedef struct packed {
    logic [31:0]         pc;
    logic [RegAddrW-1:0] a3;
    logic [31:0]         wd;
  } wb_rec_t;

  // A record only produces a register-file write when it targets a real register.
  function automatic logic wb_rec_live(input wb_rec_t rec);
    return rec.a3 != ZeroReg;
  endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter.
//   pipe_*  : in-order pipeline result stream (valid/ready, no buffering)
//   mdu_*   : multiply/divide unit result stream (valid/ready, buffered)
//   wb_*    : registered register-file write port plus committed-write counter
// Modport slave is the arbiter side; modport master is the producer/consumer side.
interface grf_wb_arbiter_if;
  import grf_wb_arbiter_pkg::*;

  logic                pipe_valid;
  logic                pipe_ready;
  logic [31:0]         pipe_pc;
  logic [RegAddrW-1:0] pipe_a3;
  logic [31:0]         pipe_wd;

  logic                mdu_valid;
  logic                mdu_ready;
  logic [31:0]         mdu_pc;
  logic [RegAddrW-1:0] mdu_a3;
  logic [31:0]         mdu_wd;

  logic                wb_we;
  logic [31:0]         wb_pc;
  logic [RegAddrW-1:0] wb_a3;
  logic [31:0]         wb_wd;
  logic [31:0]         wb_cnt;

  modport slave (
    input  pipe_valid, pipe_pc, pipe_a3, pipe_wd,
    output pipe_ready,
    input  mdu_valid, mdu_pc, mdu_a3, mdu_wd,
    output mdu_ready,
    output wb_we, wb_pc, wb_a3, wb_wd, wb_cnt
  );

  modport master (
    output pipe_valid, pipe_pc, pipe_a3, pipe_wd,
    input  pipe_ready,
    output mdu_valid, mdu_pc, mdu_a3, mdu_wd,
    input  mdu_ready,
    input  wb_we, wb_pc, wb_a3, wb_wd, wb_cnt
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of write-port records buffering MDU results.
//   clk, reset     : clock, asynchronous active-low reset (empties the FIFO)
//   push_i/data_i  : enqueue request; ignored while full
//   pop_i          : dequeue request; ignored while empty
//   head_o         : current head record (valid when !empty_o)
//   full_o/empty_o : derived from registered pointers only
module wb_result_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push_i,
  input  wb_rec_t data_i,
  input  logic    pop_i,
  output wb_rec_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  wb_rec_t       mem_q [DEPTH];
  wb_rec_t       mem_d [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Writeback arbiter for the general register file's single write port.
// Merges the pipeline result stream (priority, unbuffered) with the buffered MDU
// result stream into one registered write per cycle, bounding MDU starvation.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : pipe_* / mdu_* valid-ready inputs, wb_* registered write port,
//                wb_cnt committed-write counter (see grf_wb_arbiter_if)
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned MDU_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  grf_wb_arbiter_if.slave        bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveLimit = CntW'(STARVE_LIMIT);

  wb_rec_t pipe_rec, fifo_head, sel_rec;
  logic    fifo_full, fifo_empty;
  logic    mdu_push, pipe_sel, fifo_pop, sel_valid;

  logic            starve_mode_q, starve_mode_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            wb_we_q, wb_we_d;
  wb_rec_t         wb_rec_q, wb_rec_d;
  logic [31:0]     wb_cnt_q, wb_cnt_d;

  assign pipe_rec.pc = bus.pipe_pc;
  assign pipe_rec.a3 = bus.pipe_a3;
  assign pipe_rec.wd = bus.pipe_wd;

  wb_result_fifo #(
    .DEPTH (MDU_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (mdu_push),
    .data_i  ('{pc: bus.mdu_pc, a3: bus.mdu_a3, wd: bus.mdu_wd}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Both readies come from registered state only, so a same-cycle pop never frees
  // a slot for a same-cycle push.
  assign bus.mdu_ready  = !fifo_full;
  assign bus.pipe_ready = !starve_mode_q;

  assign mdu_push  = bus.mdu_valid && !fifo_full;
  assign pipe_sel  = bus.pipe_valid && !starve_mode_q;
  assign fifo_pop  = !pipe_sel && !fifo_empty;
  assign sel_valid = pipe_sel || fifo_pop;
  assign sel_rec   = pipe_sel ? pipe_rec : fifo_head;

  always_comb begin
    // $0 writes still consume the slot but never reach the register file.
    wb_we_d  = 1'b0;
    wb_rec_d = '0;
    if (sel_valid && wb_rec_live(sel_rec)) begin
      wb_we_d  = 1'b1;
      wb_rec_d = sel_rec;
    end

    wb_cnt_d = wb_cnt_q + {31'b0, wb_we_q};

    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveLimit) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end

    // Once the limit is hit the pipe is held off until the head has been popped.
    if (starve_mode_q) begin
      starve_mode_d = !fifo_pop;
    end else begin
      starve_mode_d = (starve_cnt_d == StarveLimit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_mode_q <= 1'b0;
      starve_cnt_q  <= '0;
      wb_we_q       <= 1'b0;
      wb_rec_q      <= '0;
      wb_cnt_q      <= '0;
    end else begin
      starve_mode_q <= starve_mode_d;
      starve_cnt_q  <= starve_cnt_d;
      wb_we_q       <= wb_we_d;
      wb_rec_q      <= wb_rec_d;
      wb_cnt_q      <= wb_cnt_d;
    end
  end

  assign bus.wb_we  = wb_we_q;
  assign bus.wb_pc  = wb_rec_q.pc;
  assign bus.wb_a3  = wb_rec_q.a3;
  assign bus.wb_wd  = wb_rec_q.wd;
  assign bus.wb_cnt = wb_cnt_q;

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Writer-side front end for the general register file's single write port (pc / write-enable / A3 / WD3).
- Merges two result producers into one registered write per cycle:
  - the in-order pipeline writeback stream (ALU/load results);
  - the long-latency multiply/divide unit (MDU) result stream.
- Buffers MDU results, gives the pipeline priority with bounded MDU starvation, and drops writes to $0.

Parameters:
- MDU_DEPTH, 2, entries in the MDU result FIFO (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty MDU FIFO may go unserved before the pipeline is stalled.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pipe_valid  input  1  pipeline result present.
- pipe_ready  output  1  pipeline result accepted this cycle when high with pipe_valid.
- pipe_pc  input  32  pc of the producing instruction.
- pipe_a3  input  5  destination register.
- pipe_wd  input  32  write data.
- mdu_valid  input  1  MDU result present.
- mdu_ready  output  1  MDU result accepted this cycle when high with mdu_valid.
- mdu_pc  input  32  pc of the producing instruction.
- mdu_a3  input  5  destination register.
- mdu_wd  input  32  write data.
- wb_we  output  1  register-file write enable.
- wb_pc  output  32  pc for the write (trace).
- wb_a3  output  5  write address.
- wb_wd  output  32  write data.
- wb_cnt  output  32  count of committed writes (wb_we pulses).

Behaviour:
- Reset (reset=0, async): FIFO emptied, starve counter = 0, starve_mode = 0, wb_we = 0, wb_pc/wb_a3/wb_wd = 0, wb_cnt = 0. Applies mid-operation: in-flight results are discarded, not written.
- mdu_ready = !fifo_full, registered-state only (no combinational path from pop). Push when mdu_valid && mdu_ready.
- pipe_ready = !starve_mode. No buffering on the pipe path.
- Per-cycle selection (one output slot):
  1. pipe_valid && pipe_ready: pipe result is selected.
  2. Otherwise, if the FIFO is non-empty: pop the head.
  3. Otherwise: no selection.
- Output registers load the selected entry on the next edge.
  - Latency: pipe accept -> wb_we = 1 cycle.
  - Latency: MDU accept -> wb_we >= 2 cycles (push, then pop).
- Zero destination: a selected entry with a3 = 0 consumes the slot, but wb_we = 0 and the fields are cleared to 0. wb_cnt is not incremented.
- No selection: wb_we = 0 and wb_pc/wb_a3/wb_wd = 0 (outputs are not held).
- Starvation:
  - starve counter increments each cycle the FIFO is non-empty and not popped.
  - The counter clears on a pop, or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, starve_mode = 1 from the next cycle. pipe_ready drops and the FIFO head pops that cycle.
  - starve_mode clears after that pop.
- FIFO full plus simultaneous pop: mdu_ready is still 0 that cycle; the push is refused and retried by the producer.
- FIFO empty plus simultaneous push: the pushed entry is eligible for pop from the next cycle only.
- wb_cnt increments by 1 on every cycle wb_we = 1 and wraps modulo 2^32.
- Order: MDU entries leave in FIFO order. Pipe order is preserved. Relative pipe/MDU order follows arbitration; data hazards are resolved upstream by the stall unit.

Decomposition:
- Shared package holds:
  - the write-port record (pc 32, a3 5, wd 32);
  - the register-address width constant (5);
  - the zero-register constant.
- One natural sub-module: wb_result_fifo, a synchronous FIFO of write-port records with full/empty flags and async active-low reset.

Test Plan:
- Pipe only: pipe_valid every cycle with a3=5 and wd=0x11, then a3=6 and wd=0x22. Required: wb_we=1 one cycle later with wb_a3=5/wb_wd=0x11, then 6/0x22. wb_cnt = 2.
- MDU only: one mdu push with pc=0x3000, a3=8, wd=0xDEAD_BEEF. Required: wb_we exactly 2 cycles after accept with matching fields. mdu_ready stays 1.
- Starvation: FIFO holds one entry, pipe_valid held high continuously. Required: after 4 unserved cycles, pipe_ready=0 for one cycle, the MDU entry is written, then pipe_ready=1 again.
- Full FIFO: push 2 MDU results while the pipe streams. Required: mdu_ready=0 on the third attempt; the entry is accepted only after a pop. All 3 entries are written in order.
- Zero register: pipe result with a3=0, wd=0x1234. Required: wb_we=0, wb_wd=0, wb_cnt unchanged, pipe_ready=1.
- Reset mid-operation: FIFO holds 2 entries, drive reset=0 asynchronously between edges. Required: immediately wb_we=0 and wb_cnt=0; after release, mdu_ready=1 and no stale writes appear.
